// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N requesters.
//
// A grant lasts for up to MAX_BURST accepted words. It ends early if the owner drops req.
// At the end of a burst the next owner is picked in the same cycle, so there is no idle
// cycle between bursts. The owner that just finished has the lowest priority in that pick.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        per-requester write request (bit i = requester i)
//   req_data   flattened write data, requester i at [i*DW +: DW]
//   ack        one-cycle pulse: requester i's current word was written this cycle
//   fifo_full  FIFO full flag; blocks writes while set
//   fifo_wr    FIFO write strobe
//   fifo_data  FIFO write data
//   grant_id   current owner; valid only while busy
//   busy       a grant is active
//   word_cnt   (FIFO_ARB_STATS_EN only) per-requester saturating 16-bit word counters
//
// Optional feature: define FIFO_ARB_STATS_EN to add the word_cnt port and its counters.
module fifo_wr_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      req_data,
    output logic [N-1:0]         ack,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [DW-1:0]        fifo_data,
    output logic [$clog2(N)-1:0] grant_id,
`ifdef FIFO_ARB_STATS_EN
    output logic [N*16-1:0]      word_cnt,
`endif
    output logic                 busy
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [OW-1:0]   rr_q, rr_d;

    logic [OW-1:0]   pick_base;
    logic [OW-1:0]   cand;
    logic [OW-1:0]   pick_id;
    logic            pick_valid;
    logic            burst_end;

    // Write-port outputs; all low in IDLE, which covers the reset case combinationally.
    always_comb begin
        fifo_wr   = 1'b0;
        fifo_data = '0;
        ack       = '0;
        if (state_q == StGrant) begin
            fifo_wr      = req[owner_q] & ~fifo_full;
            fifo_data    = req_data[owner_q*DW +: DW];
            ack[owner_q] = fifo_wr;
        end
    end

    assign busy     = (state_q == StGrant);
    assign grant_id = owner_q;

    // Round-robin pick: scan base+1 .. base+N (mod N). Scanning downward lets the nearest
    // requester overwrite farther ones. In GRANT the pick is only used at burst end, where
    // the new rr pointer equals the current owner, so owner_q is the base.
    always_comb begin
        pick_base  = (state_q == StGrant) ? owner_q : rr_q;
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = int'(N); i >= 1; i--) begin
            cand = OW'((int'(pick_base) + i) % int'(N));
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign burst_end = (state_q == StGrant) &&
                       ((fifo_wr && (beat_q == BW'(MAX_BURST - 1))) || !req[owner_q]);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    owner_d = pick_id;
                    beat_d  = '0;
                end
            end
            StGrant: begin
                if (burst_end) begin
                    rr_d = owner_q;
                    if (pick_valid) begin
                        owner_d = pick_id;
                        beat_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (fifo_wr) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            beat_q  <= '0;
            rr_q    <= OW'(N - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            rr_q    <= rr_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] word_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (ack[i] && (word_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                    word_cnt_q[i*16 +: 16] <= word_cnt_q[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. Directed scenarios followed by a random phase.
// Every cycle is checked against a burst-level reference model of the arbiter.
module tb_fifo_wr_arbiter;

    localparam int unsigned N         = 4;
    localparam int unsigned DW        = 32;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned OW        = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      ack;
    logic              fifo_full;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_data;
    logic [OW-1:0]     grant_id;
    logic              busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0]   word_cnt;
`endif

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
`ifdef FIFO_ARB_STATS_EN
        .word_cnt  (word_cnt),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: whether a burst is running, who owns it, how many words it has
    // written, and who finished the last burst (the round-robin reference point).
    int           m_busy, m_owner, m_words, m_last;
    logic [N-1:0] last_ack;
    logic [N-1:0] obs_ack;
    logic         obs_wr, obs_busy;
    logic [OW-1:0] obs_grant;
    logic [DW-1:0] obs_data;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_words = 0; m_last = N - 1; last_ack = '0;
    endtask

    // First requester after 'after' in circular order, or -1 if nobody requests.
    function automatic int next_owner(input int after);
        for (int k = 1; k <= int'(N); k++) begin
            int c;
            c = (after + k) % int'(N);
            if (req[c[OW-1:0]]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: inputs are already set; compare at the falling edge, advance model.
    task automatic step();
        logic          e_wr;
        logic [N-1:0]  e_ack;
        logic [DW-1:0] e_data;
        int            nxt;
        @(negedge clock);
        e_wr   = (m_busy != 0) && req[m_owner[OW-1:0]] && !fifo_full;
        e_ack  = e_wr ? (N'(1) << m_owner) : '0;
        e_data = (m_busy != 0) ? req_data[m_owner*DW +: DW] : '0;
        obs_ack = ack; obs_wr = fifo_wr; obs_busy = busy; obs_grant = grant_id;
        obs_data = fifo_data;
        check_eq("fifo_wr", 64'(fifo_wr), 64'(e_wr));
        check_eq("ack", 64'(ack), 64'(e_ack));
        check_eq("fifo_data", 64'(fifo_data), 64'(e_data));
        check_eq("busy", 64'(busy), 64'(m_busy != 0));
        if (m_busy != 0) check_eq("grant_id", 64'(grant_id), 64'(m_owner));
        last_ack = e_ack;
        if ((m_busy != 0) &&
            ((e_wr && (m_words + 1 == int'(MAX_BURST))) || !req[m_owner[OW-1:0]])) begin
            m_last = m_owner;
            m_busy = 0;
        end else if (e_wr) begin
            m_words++;
        end
        if (m_busy == 0) begin
            nxt = next_owner(m_last);
            if (nxt >= 0) begin
                m_busy = 1; m_owner = nxt; m_words = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // After an ack: present a fresh word if keep[i], otherwise drop the request.
    task automatic refresh(input logic [N-1:0] keep);
        for (int i = 0; i < int'(N); i++) begin
            if (last_ack[i]) begin
                if (keep[i]) req_data[i*DW +: DW] = $urandom;
                else req[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = '0; fifo_full = 1'b0;
        for (int i = 0; i < int'(N); i++) req_data[i*DW +: DW] = $urandom;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    logic [DW-1:0] words [6];
    int            acks;
    int            per_req [N];

    initial begin
        reset_n = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0;
        model_reset();

        // Reset mid-burst: owner 2 after two words, then reset between edges.
        do_reset();
        req = 4'b0100;
        step();
        step(); refresh(4'b0100);
        step(); refresh(4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_fifo_wr", 64'(fifo_wr), 64'(0));
        check_eq("rst_ack", 64'(ack), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_grant_id", 64'(grant_id), 64'(0));
        check_eq("rst_fifo_data", 64'(fifo_data), 64'(0));
        req = 4'b1111;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        step();
        step();
        check_eq("t1_first_grant", 64'(obs_grant), 64'(0));
        check_eq("t1_first_ack", 64'(obs_ack), 64'(4'b0001));

        // Single requester, six words back to back across a re-grant.
        do_reset();
        for (int k = 0; k < 6; k++) words[k] = $urandom;
        acks = 0;
        req = 4'b0010;
        req_data[1*DW +: DW] = words[0];
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("t2_ack", 64'(obs_ack), 64'((c >= 1 && c <= 6) ? 4'b0010 : 4'b0000));
            if (c >= 1 && c <= 6) check_eq("t2_data", 64'(obs_data), 64'(words[c-1]));
            if (last_ack[1]) begin
                acks++;
                if (acks < 6) req_data[1*DW +: DW] = words[acks];
                else req[1] = 1'b0;
            end
        end

        // All requesters continuous: four-word bursts rotating 0,1,2,3.
        do_reset();
        for (int i = 0; i < int'(N); i++) per_req[i] = 0;
        req = 4'b1111;
        step();
        for (int k = 0; k < 32; k++) begin
            step();
            check_eq("t3_grant", 64'(obs_grant), 64'((k / 4) % 4));
            check_eq("t3_ack", 64'(obs_ack), 64'(4'b0001 << ((k / 4) % 4)));
            for (int i = 0; i < int'(N); i++) if (last_ack[i]) per_req[i]++;
            refresh(4'b1111);
        end
        for (int i = 0; i < int'(N); i++) check_eq("t3_count", 64'(per_req[i]), 64'(8));

        // Stall after two beats of owner 1; burst resumes, then grant moves to 2.
        do_reset();
        req = 4'b0110;
        step();
        repeat (2) begin step(); refresh(4'b0110); end
        fifo_full = 1'b1;
        repeat (3) begin
            step();
            check_eq("t4_stall_wr", 64'(obs_wr), 64'(0));
            check_eq("t4_stall_grant", 64'(obs_grant), 64'(1));
        end
        fifo_full = 1'b0;
        repeat (2) begin
            step();
            check_eq("t4_resume_ack", 64'(obs_ack), 64'(4'b0010));
            refresh(4'b0110);
        end
        step();
        check_eq("t4_next_grant", 64'(obs_grant), 64'(2));
        check_eq("t4_next_ack", 64'(obs_ack), 64'(4'b0100));

        // Early release by owner 2 with requester 3 waiting.
        do_reset();
        req = 4'b1100;
        step();
        step(); refresh(4'b1100);
        step(); refresh(4'b1000);
        step();
        check_eq("t5_drop_busy", 64'(obs_busy), 64'(1));
        check_eq("t5_drop_wr", 64'(obs_wr), 64'(0));
        step();
        check_eq("t5_grant", 64'(obs_grant), 64'(3));
        check_eq("t5_ack", 64'(obs_ack), 64'(4'b1000));

`ifdef FIFO_ARB_STATS_EN
        // Counter saturation from a single requester.
        do_reset();
        req = 4'b0001;
        step();
        repeat (70000) begin step(); refresh(4'b0001); end
        check_eq("t6_cnt0", 64'(word_cnt[15:0]), 64'(16'hFFFF));
        for (int i = 1; i < int'(N); i++) check_eq("t6_cnt_other", 64'(word_cnt[i*16 +: 16]), 64'(0));
`endif

        // Random traffic: requests come and go, occasional drops without ack, random full.
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < int'(N); i++) begin
                if (last_ack[i]) begin
                    if ($urandom_range(0, 3) != 0) req_data[i*DW +: DW] = $urandom;
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        req_data[i*DW +: DW] = $urandom;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
